// File: rtl/uartlite_ctrl.sv
// AXI4-Lite master that sequences a UARTLite slave: FIFO reset, then a STAT poll
// loop that round-robins between draining RX and pushing TX through one-deep holding registers.
module uartlite_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        err,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_awaddr,
  output logic [2:0]  axi_awprot,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  input  logic [1:0]  axi_bresp,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  output logic [31:0] axi_araddr,
  output logic [2:0]  axi_arprot,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp
);

  localparam logic [31:0] RX_ADDR   = BASE_ADDR + 32'h0;
  localparam logic [31:0] TX_ADDR   = BASE_ADDR + 32'h4;
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'h8;
  localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'hC;

  typedef enum logic [2:0] {INIT_W, INIT_B, STAT_AR, STAT_R, RX_AR, RX_R, TX_W, TX_B} state_t;

  state_t     state;
  logic       aw_done, w_done, rr_last_rx;
  logic [7:0] tx_buf;
  logic       stat_ok, rx_ok, tx_ok, pick_rx, aw_now, w_now;
  logic       unused_ok;

  assign axi_awprot = 3'b000;
  assign axi_arprot = 3'b000;
  assign axi_wstrb  = 4'b1111;
  assign unused_ok  = ^axi_rdata[31:8] ^ ^axi_rdata[2:1] ^ ^axi_rdata[7:4];

  always_comb begin
    stat_ok = (axi_rresp == 2'b00);
    rx_ok   = stat_ok & axi_rdata[0] & ~rx_valid;
    tx_ok   = stat_ok & ~axi_rdata[3] & ~tx_ready;
    pick_rx = rx_ok & (~tx_ok | ~rr_last_rx);
    aw_now  = aw_done | (axi_awvalid & axi_awready);
    w_now   = w_done  | (axi_wvalid  & axi_wready);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= INIT_W;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      axi_awaddr  <= '0;
      axi_wdata   <= '0;
      axi_araddr  <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      tx_ready    <= 1'b0;
      tx_buf      <= '0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      err         <= 1'b0;
      rr_last_rx  <= 1'b0;
    end else begin
      if (tx_valid && tx_ready) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        INIT_W, TX_W: begin
          // Address and data channels complete independently; B waits for both.
          if (axi_awvalid && axi_awready) begin
            axi_awvalid <= 1'b0;
            aw_done     <= 1'b1;
          end else if (!aw_done) begin
            axi_awvalid <= 1'b1;
            axi_awaddr  <= (state == INIT_W) ? CTRL_ADDR : TX_ADDR;
          end
          if (axi_wvalid && axi_wready) begin
            axi_wvalid <= 1'b0;
            w_done     <= 1'b1;
          end else if (!w_done) begin
            axi_wvalid <= 1'b1;
            axi_wdata  <= (state == INIT_W) ? 32'h3 : {24'h0, tx_buf};
          end
          if (aw_now && w_now) begin
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            axi_bready  <= 1'b1;
            state       <= (state == INIT_W) ? INIT_B : TX_B;
          end
        end
        INIT_B, TX_B: begin
          if (axi_bvalid) begin
            axi_bready  <= 1'b0;
            if (axi_bresp != 2'b00) err <= 1'b1;
            tx_ready    <= 1'b1;
            if (state == TX_B) rr_last_rx <= 1'b0;
            axi_arvalid <= 1'b1;
            axi_araddr  <= STAT_ADDR;
            state       <= STAT_AR;
          end
        end
        STAT_AR, RX_AR: begin
          if (axi_arvalid && axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= (state == STAT_AR) ? STAT_R : RX_R;
          end else begin
            axi_arvalid <= 1'b1;
          end
        end
        STAT_R: begin
          if (axi_rvalid) begin
            axi_rready <= 1'b0;
            if (!stat_ok) err <= 1'b1;
            if (pick_rx) begin
              axi_arvalid <= 1'b1;
              axi_araddr  <= RX_ADDR;
              state       <= RX_AR;
            end else if (tx_ok) begin
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
              axi_awaddr  <= TX_ADDR;
              axi_wdata   <= {24'h0, tx_buf};
              state       <= TX_W;
            end else begin
              axi_arvalid <= 1'b1;
              axi_araddr  <= STAT_ADDR;
              state       <= STAT_AR;
            end
          end
        end
        RX_R: begin
          if (axi_rvalid) begin
            axi_rready <= 1'b0;
            // RX is only chosen with the holding register empty, so no clash with consume.
            if (axi_rresp == 2'b00) begin
              rx_data  <= axi_rdata[7:0];
              rx_valid <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            rr_last_rx  <= 1'b1;
            axi_arvalid <= 1'b1;
            axi_araddr  <= STAT_ADDR;
            state       <= STAT_AR;
          end
        end
        default: state <= INIT_W;
      endcase
    end
  end

endmodule

// File: tb/tb_uartlite_ctrl.sv
// Directed bench for uartlite_ctrl: negedge-driven UARTLite slave model plus hand-computed checks.
module tb_uartlite_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_ready, rx_valid, rx_ready = 1'b0, err;
  logic [7:0]  rx_data;
  logic        awvalid, awready = 1'b1, wvalid, wready = 1'b1, bvalid = 1'b0, bready;
  logic        arvalid, arready = 1'b1, rvalid = 1'b0, rready;
  logic [31:0] awaddr, wdata, araddr, rdata = '0;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;

  uartlite_ctrl dut (
    .clk(clk), .rstn(rstn),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .err(err),
    .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr), .axi_awprot(awprot),
    .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb),
    .axi_bvalid(bvalid), .axi_bready(bready), .axi_bresp(bresp),
    .axi_arvalid(arvalid), .axi_arready(arready), .axi_araddr(araddr), .axi_arprot(arprot),
    .axi_rvalid(rvalid), .axi_rready(rready), .axi_rdata(rdata), .axi_rresp(rresp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Slave knobs and observation counters
  logic [31:0] stat_val = '0;
  logic [7:0]  rx_val = '0;
  logic [1:0]  rx_resp = 2'b00;
  int          aw_wait = 0;
  int          aw_hi = 0, w_hi = 0, b_early = 0;
  int          n_tx_wr = 0, n_rx_rd = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, r_addr = '0;
  logic        got_aw = 1'b0, got_w = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
  int          dq[$];  // data accesses in order: 0 = RX read, 1 = TX write

  // Values set at a negedge are what the DUT samples at the next posedge.
  always @(negedge clk) begin
    if (!rstn) begin
      bvalid = 1'b0; rvalid = 1'b0; awready = 1'b1; wready = 1'b1; arready = 1'b1;
      got_aw = 1'b0; got_w = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
    end else begin
      bvalid = b_pend;
      bresp  = 2'b00;
      if (bvalid && bready) b_pend = 1'b0;
      rvalid = r_pend;
      rdata  = (r_addr == 32'h8) ? stat_val : {24'h0, rx_val};
      rresp  = (r_addr == 32'h0) ? rx_resp : 2'b00;
      if (rvalid && rready) r_pend = 1'b0;
      if (awvalid && aw_wait > 0) begin
        awready = 1'b0;
        aw_wait--;
      end else begin
        awready = 1'b1;
      end
      wready  = 1'b1;
      arready = 1'b1;
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (bready && (awvalid || wvalid)) b_early++;
      if (awvalid && awready) begin
        got_aw = 1'b1;
        last_awaddr = awaddr;
        if (awaddr == 32'h4) begin
          n_tx_wr++;
          dq.push_back(1);
        end
      end
      if (wvalid && wready) begin
        got_w = 1'b1;
        last_wdata = wdata;
      end
      if (got_aw && got_w) begin
        b_pend = 1'b1;
        got_aw = 1'b0;
        got_w  = 1'b0;
      end
      if (arvalid && arready) begin
        r_pend = 1'b1;
        r_addr = araddr;
        if (araddr == 32'h0) begin
          n_rx_rd++;
          dq.push_back(0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0;
    repeat (3) step();
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx", {rx_valid, rx_data}, 0);
    chk("rst_err", err, 0);
    chk("rst_axi_vld", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rst_payload", awaddr | araddr | wdata, 0);
    chk("const_prot_strb", {awprot, arprot, wstrb}, 32'h00F);

    // Reset release: FIFO-reset write, then first STAT read
    rstn = 1'b1;
    step();
    chk("init_aw_w_vld", {awvalid, wvalid}, 2'b11);
    chk("init_awaddr", awaddr, 32'hC);
    chk("init_wdata", wdata, 32'h3);
    chk("init_tx_ready", tx_ready, 0);
    step();
    chk("init_b_bready", bready, 1);
    chk("init_b_tx_ready", tx_ready, 0);
    step();
    chk("post_init_tx_ready", tx_ready, 1);
    chk("stat_ar", {arvalid, araddr}, {1'b1, 32'h8});

    // RX fill, hold while full, consume and refill
    stat_val = 32'h1; rx_val = 8'h41;
    for (int i = 0; i < 30 && !rx_valid; i++) step();
    chk("rx_valid_set", rx_valid, 1);
    chk("rx_data_41", rx_data, 8'h41);
    n = n_rx_rd;
    repeat (20) step();
    chk("rx_full_no_read", n_rx_rd, n);
    chk("rx_full_hold", {rx_valid, rx_data}, {1'b1, 8'h41});
    rx_val = 8'h42; rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    chk("rx_consumed", rx_valid, 0);
    for (int i = 0; i < 30 && !rx_valid; i++) step();
    chk("rx_refill", {rx_valid, rx_data}, {1'b1, 8'h42});
    chk("rx_refill_reads", n_rx_rd, n + 1);
    stat_val = 32'h0; rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    repeat (10) step();
    chk("rx_drained", rx_valid, 0);

    // TX write, then blocked by TX-full status
    n = n_tx_wr;
    tx_data = 8'h5A; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    chk("tx_accept", tx_ready, 0);
    for (int i = 0; i < 40 && n_tx_wr != n + 1; i++) step();
    chk("tx_wr_count", n_tx_wr, n + 1);
    chk("tx_awaddr", last_awaddr, 32'h4);
    chk("tx_wdata", last_wdata, 32'h5A);
    for (int i = 0; i < 20 && !tx_ready; i++) step();
    chk("tx_ready_back", tx_ready, 1);
    stat_val = 32'h8;
    repeat (4) step();
    tx_data = 8'h77; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    repeat (20) step();
    chk("tx_full_no_write", n_tx_wr, n + 1);
    chk("tx_full_pending", tx_ready, 0);
    stat_val = 32'h0;
    for (int i = 0; i < 40 && n_tx_wr != n + 2; i++) step();
    chk("tx_unblocked_wdata", last_wdata, 32'h77);
    for (int i = 0; i < 20 && !tx_ready; i++) step();
    chk("tx_unblocked_ready", tx_ready, 1);

    // Both sides busy: RX, TX, RX, TX alternation
    d0 = dq.size();
    stat_val = 32'h1; rx_ready = 1'b1; tx_data = 8'hA5; tx_valid = 1'b1;
    for (int i = 0; i < 200 && dq.size() < d0 + 4; i++) step();
    chk("rr_count", (dq.size() >= d0 + 4), 1);
    if (dq.size() >= d0 + 4) begin
      chk("rr_0_rx", dq[d0], 0);
      chk("rr_1_tx", dq[d0 + 1], 1);
      chk("rr_2_rx", dq[d0 + 2], 0);
      chk("rr_3_tx", dq[d0 + 3], 1);
    end
    tx_valid = 1'b0; stat_val = 32'h0;
    repeat (20) step();
    rx_ready = 1'b0;
    chk("rr_drain", {tx_ready, rx_valid}, 2'b10);

    // Delayed AWREADY with immediate WREADY
    aw_wait = 3; aw_hi = 0; w_hi = 0; b_early = 0;
    n = n_tx_wr;
    tx_data = 8'h3C; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    for (int i = 0; i < 60 && !(n_tx_wr == n + 1 && tx_ready); i++) step();
    chk("slow_aw_hold", aw_hi, 4);
    chk("slow_aw_w_once", w_hi, 1);
    chk("slow_aw_b_order", b_early, 0);
    chk("slow_aw_wdata", last_wdata, 32'h3C);

    // RX read error response
    rx_resp = 2'b10; stat_val = 32'h1;
    n = n_rx_rd;
    for (int i = 0; i < 40 && n_rx_rd < n + 1; i++) step();
    repeat (3) step();
    chk("rresp_err", err, 1);
    chk("rresp_drop", rx_valid, 0);
    rx_resp = 2'b00; stat_val = 32'h0;
    repeat (5) step();
    chk("err_sticky", err, 1);

    // Async reset in the middle of TX_B
    tx_data = 8'h11; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    for (int i = 0; i < 40 && !bready; i++) step();
    chk("txb_reached", bready, 1);
    rstn = 1'b0;
    #1;
    chk("async_axi_vld", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("async_payload", awaddr | araddr | wdata, 0);
    chk("async_core", {tx_ready, rx_valid, rx_data, err}, 0);
    step();
    rstn = 1'b1;
    step();
    chk("restart_init", {awvalid, awaddr}, {1'b1, 32'hC});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uartlite_ctrl.md
Name: uartlite_ctrl

Overview:
- AXI4-Lite master sequencer that owns a Xilinx-style UARTLite slave and arbitrates it between a byte transmitter and a byte receiver.
- After reset it resets both UARTLite FIFOs, then loops: read STAT, then serve RX or TX by round-robin.
- Presents one-deep TX and RX holding registers with valid/ready handshakes to the core.

Parameters:
- BASE_ADDR, 32'h0000_0000, UARTLite base address. Registers: RX=+0x0, TX=+0x4, STAT=+0x8, CTRL=+0xC.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- tx_valid  input  1  core offers a TX byte
- tx_data  input  8  TX byte
- tx_ready  output  1  TX holding register empty
- rx_valid  output  1  RX holding register full
- rx_data  output  8  RX byte
- rx_ready  input  1  core consumes the RX byte
- err  output  1  sticky: a bresp or rresp other than OKAY was seen
- axi_awvalid/axi_awready/axi_awaddr  out/in/out  1/1/32  write address channel
- axi_awprot  output  3  constant 3'b000
- axi_wvalid/axi_wready/axi_wdata/axi_wstrb  out/in/out/out  1/1/32/4  write data channel; wstrb constant 4'b1111
- axi_bvalid/axi_bready/axi_bresp  in/out/in  1/1/2  write response channel
- axi_arvalid/axi_arready/axi_araddr  out/in/out  1/1/32  read address channel
- axi_arprot  output  3  constant 3'b000
- axi_rvalid/axi_rready/axi_rdata/axi_rresp  in/out/in/in  1/1/32/2  read data channel

Behaviour:
- Reset (rstn=0, async): state=INIT_W; all AXI valid/ready outputs 0; awaddr, araddr and wdata 0; tx_ready=0; rx_valid=0; rx_data=0; err=0; rr_last_rx=0. Reset mid-transaction abandons the bus cycle immediately.
- Write cycle, used by INIT_W and TX_W:
  - awvalid and wvalid both assert on state entry.
  - Each drops independently on its own handshake (aw_done and w_done flags).
  - Once both are done, go to the matching B state with bready=1 until bvalid.
- Read cycle, used by STAT_AR and RX_AR:
  - arvalid is held until arready, then go to the matching R state with rready=1 until rvalid.
- States:
  - INIT_W: awaddr=BASE+0xC, wdata=32'h3 (reset TX and RX FIFOs) -> INIT_B.
  - INIT_B: on bvalid -> STAT_AR.
  - STAT_AR: araddr=BASE+0x8 -> STAT_R.
  - STAT_R: on rvalid, capture rv=rdata[0] and tf=rdata[3].
    - rx_ok = rv & ~rx_valid.
    - tx_ok = ~tf & tx_full, where tx_full = ~tx_ready.
    - If both: serve RX when rr_last_rx=0, else TX.
    - If only one is ok, serve that one. If neither, go to STAT_AR.
    - Choosing RX goes to RX_AR; choosing TX goes to TX_W.
    - If rresp != OKAY: set err, treat both as not ok, go to STAT_AR.
  - RX_AR: araddr=BASE+0x0 -> RX_R.
  - RX_R: on rvalid with OKAY: rx_data<=rdata[7:0], rx_valid<=1. On error: set err and drop the byte. Then rr_last_rx<=1 -> STAT_AR.
  - TX_W: awaddr=BASE+0x4, wdata={24'h0,tx_buf} -> TX_B.
  - TX_B: on bvalid: tx_ready<=1, rr_last_rx<=0. bresp error sets err and the byte is counted as sent. -> STAT_AR.
- tx_ready stays 0 until INIT_B completes, then follows holding-register emptiness.
- TX accept: tx_valid & tx_ready latches tx_buf and sets tx_ready=0 the next cycle.
- RX consume: rx_valid & rx_ready clears rx_valid the next cycle.
- RX writes the holding register only when it is empty, so it never collides with consumption.
- Minimum STAT->RX->rx_valid latency: 4 cycles with zero-wait slave. Minimum TX accept->tx_ready latency: 5 cycles with zero-wait slave.
- AXI outputs are registered, with no combinational path from any input to any AXI valid.
- Payload signals hold stable while valid is high and ready is low.

Test Plan:
- Reset release, zero-wait slave -> first transaction is AW 0xC / W 0x3 in the same cycle; tx_ready=0 until its B completes; next transaction is AR 0x8.
- STAT=0x1, RX=0x41, rx_ready=0 -> rx_valid=1 and rx_data=8'h41. Further STAT=0x1 polls issue no AR to 0x0 until rx_ready pulses.
- tx_valid with 8'h5A, STAT=0x0 -> AW 0x4 / W 0x5A. tx_ready returns to 1 after B. A STAT with bit3=1 (0x8) must produce no TX write.
- STAT=0x1 with a TX pending, repeated -> accesses alternate RX, TX, RX; rr_last_rx toggles accordingly.
- AWREADY delayed 3 cycles while WREADY is immediate -> wvalid drops after 1 cycle, awvalid is held 4 cycles, and bready rises only after both handshakes.
- rresp=2'b10 on an RX read -> err=1 (sticky), rx_valid stays 0; rstn pulse mid-TX_B -> all outputs return to their reset values asynchronously.
